// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath. The controller sequences it with load/add/shift/ready.
// The datapath keeps the operand registers, tracks protocol errors, and registers the product.
module mult_datapath #(
   parameter int N = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             add_i,
   input  logic             shift_i,
   input  logic             ready_i,
   input  logic [N-1:0]     mcand_i,
   input  logic [N-1:0]     mplier_i,
   output logic             m0_o,
   output logic [2*N-1:0]   product_o,
   output logic             p_valid_o,
   output logic             err_o
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_N   = CW'(N);

   logic [N-1:0]   m_q,       m_d;
   logic [N:0]     acc_q,     acc_d;
   logic [N-1:0]   q_q,       q_d;
   logic           busy_q,    busy_d;
   logic [CW-1:0]  cnt_q,     cnt_d;
   logic [2*N-1:0] product_q, product_d;
   logic           pv_q,      pv_d;
   logic           err_q,     err_d;

   logic           done;
   logic           do_add;
   logic           do_shift;
   logic [2*N:0]   shifted;

   assign done     = ready_i & busy_q;
   assign do_add   = add_i & ~load_i;
   assign do_shift = shift_i & ~load_i & ~add_i;
   assign shifted  = {acc_q, q_q} >> 1;

   always_comb begin
      m_d       = m_q;
      acc_d     = acc_q;
      q_d       = q_q;
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      pv_d      = done;
      err_d     = err_q;

      // Completion samples the pre-action registers, even when a load lands in the same cycle
      if (done) begin
         product_d = {acc_q[N-1:0], q_q};
         busy_d    = 1'b0;
         if ((cnt_q != CNT_N) || acc_q[N])
            err_d = 1'b1;
      end

      if ((do_add || do_shift) && !busy_q)
         err_d = 1'b1;

      if (load_i) begin
         m_d    = mcand_i;
         q_d    = mplier_i;
         acc_d  = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (do_add) begin
         acc_d = acc_q + {1'b0, m_q};
      end else if (do_shift) begin
         acc_d = shifted[2*N:N];
         q_d   = shifted[N-1:0];
         if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q       <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
         pv_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         m_q       <= m_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         pv_q      <= pv_d;
         err_q     <= err_d;
      end
   end

   assign m0_o      = q_q[0];
   assign product_o = product_q;
   assign p_valid_o = pv_q;
   assign err_o     = err_q;

endmodule

// File: doc/mult_datapath.md
MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 Parameter: N, default 4, operand width in bits; legal range 2..16.
REQ-002 clk  input  1  clock; all registers update on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  from sequencing controller: capture operands, clear accumulator.
REQ-005 add  input  1  from controller: accumulator += multiplicand.
REQ-006 shift  input  1  from controller: shift {acc,q} right one bit.
REQ-007 ready  input  1  from controller: controller idle.
REQ-008 mcand  input  N  multiplicand operand, sampled on load.
REQ-009 mplier  input  N  multiplier operand, sampled on load.
REQ-010 m0  output  1  current multiplier LSB (q[0]), fed back to controller.
REQ-011 product  output  2N  last completed product, registered.
REQ-012 p_valid  output  1  one-cycle pulse: product just updated.
REQ-013 err  output  1  sticky protocol-error flag.

Function
REQ-014 Internal registers: m_reg (N bits), acc (N+1 bits, MSB = carry), q (N bits), busy (1 bit), shift_cnt (ceil(log2(N+1)) bits).
REQ-015 m0 SHALL be combinational q[0], no added latency.
REQ-016 load: m_reg<=mcand, q<=mplier, acc<=0, shift_cnt<=0, busy<=1 at next edge.
REQ-017 add: acc<=acc+{0,m_reg}, N+1-bit unsigned sum; carry into acc[N], no overflow beyond N+1 bits.
REQ-018 shift: {acc,q}<={0,acc,q}>>1 as one 2N+1-bit logical shift, zero fill at acc[N]; shift_cnt increments by 1, saturating at max.
REQ-019 Priority when asserted together: load > add > shift; lower-priority action ignored that cycle.
REQ-020 No control asserted: acc, q, m_reg, shift_cnt hold.
REQ-021 Completion: cycle with ready=1 and busy=1 -> product<={acc[N-1:0],q}, p_valid=1 next cycle, busy<=0.
REQ-022 p_valid SHALL be exactly one cycle per completion; ready with busy=0 produces no pulse and leaves product unchanged.
REQ-023 Completion and load in same cycle (back-to-back start): product captures pre-load {acc[N-1:0],q}, p_valid pulses, operand registers take new values, busy stays 1.
REQ-024 Completion with shift_cnt!=N, or acc[N]=1 at completion: err<=1; product still captured.
REQ-025 add or shift while busy=0: err<=1; datapath action still performed.
REQ-026 err SHALL clear only on reset.
REQ-027 Latency: product valid 1 cycle after the completion cycle; m0 valid same cycle as q changes.

Reset
REQ-028 reset=1 SHALL asynchronously force m_reg=0, acc=0, q=0, busy=0, shift_cnt=0, product=0, p_valid=0, err=0; thus m0=0.
REQ-029 Reset mid-operation SHALL abort the multiply with no p_valid and product=0; the first edge after deassertion acts on control inputs normally.

Verification
REQ-030 N=4, load mcand=13 mplier=11, controller sequence add,shift,add,shift,shift,add,shift, then ready -> product=0x8F (143), p_valid one cycle, err=0.
REQ-031 N=4, 15x15 with four add/shift pairs -> intermediate acc[4]=1 after add, final product=0xE1 (225), err=0.
REQ-032 N=4, 0x9 (mplier=0): four shifts only, ready -> product=0x00, p_valid=1; m0=0 throughout.
REQ-033 Back-to-back: ready+load same cycle after 13x11 with new 9x1 -> product=0x8F pulse; next completion product=0x09.
REQ-034 reset asserted after second shift of 7x5 -> all outputs 0 immediately, no p_valid; following 3x3 gives product=0x09.
REQ-035 Protocol error: load, three shifts, ready -> err=1 and stays 1 until reset; shift with busy=0 -> err=1.
